alu_bist_ctrl: RTL

// - Built-in self-test initiator for the 32-bit ALU: drives inA/inB/operation, samples result/zero.
// - Sweeps all 16 opcodes with corner and LFSR operands; compacts results into a 32-bit MISR

---
 rtl/alu_bist_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_bist_ctrl.sv
// BIST initiator for the 32-bit ALU: sweeps 16 opcodes with corner and LFSR operands into a MISR.
// Optional ALU_BIST_STOP_ON_ERR_EN: stop at the first zero-flag inconsistency and freeze the vector.
module alu_bist_ctrl #(
    parameter int          PATTERNS   = 64,
    parameter logic [31:0] SEED_A     = 32'hACE12468,
    parameter logic [31:0] SEED_B     = 32'h13579BDF,
    parameter logic [31:0] GOLDEN_SIG = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        zero_err,
    output logic [31:0] signature,
    output logic [31:0] alu_inA,
    output logic [31:0] alu_inB,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    localparam int VW = $clog2(PATTERNS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_CAPTURE, S_DONE} state_t;

    function automatic logic [31:0] f_lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] f_misr_step(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
    endfunction

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_zerr;
    logic [31:0]     r_sig;
    logic [31:0]     r_inA;
    logic [31:0]     r_inB;
    logic [3:0]      r_op;
    logic [VW-1:0]   r_vec;
    logic [31:0]     r_lfsr_a;
    logic [31:0]     r_lfsr_b;

    logic [31:0]     w_sig_nx;
    logic            w_zmis;
    logic            w_zerr_nx;
    logic            w_last_vec;
    logic            w_to_done;
    logic [VW-1:0]   w_vec_nx;
    logic [3:0]      w_op_nx;
    logic [31:0]     w_lfsr_a_nx;
    logic [31:0]     w_lfsr_b_nx;
    logic [31:0]     w_inA_nx;
    logic [31:0]     w_inB_nx;

    always_comb begin
        w_sig_nx   = f_misr_step(r_sig, alu_result);
        w_zmis     = alu_zero != (alu_result == 32'h0);
        w_zerr_nx  = r_zerr | w_zmis;
        w_last_vec = r_vec == VW'(PATTERNS - 1);
`ifdef ALU_BIST_STOP_ON_ERR_EN
        w_to_done  = (w_last_vec && (r_op == 4'hF)) || w_zmis;
`else
        w_to_done  = w_last_vec && (r_op == 4'hF);
`endif
        w_vec_nx   = w_last_vec ? '0 : r_vec + VW'(1);
        w_op_nx    = w_last_vec ? r_op + 4'd1 : r_op;
        // LFSRs advance only after a k>=2 vector and reseed at each opcode change
        if (w_last_vec) begin
            w_lfsr_a_nx = SEED_A;
            w_lfsr_b_nx = SEED_B;
        end else if (r_vec >= VW'(2)) begin
            w_lfsr_a_nx = f_lfsr_step(r_lfsr_a);
            w_lfsr_b_nx = f_lfsr_step(r_lfsr_b);
        end else begin
            w_lfsr_a_nx = r_lfsr_a;
            w_lfsr_b_nx = r_lfsr_b;
        end
        if (w_vec_nx == '0) begin
            w_inA_nx = 32'h0;
            w_inB_nx = 32'h0;
        end else if (w_vec_nx == VW'(1)) begin
            w_inA_nx = 32'hFFFFFFFF;
            w_inB_nx = 32'hFFFFFFFF;
        end else begin
            w_inA_nx = w_lfsr_a_nx;
            w_inB_nx = w_lfsr_b_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_zerr   <= 1'b0;
            r_sig    <= 32'h0;
            r_inA    <= 32'h0;
            r_inB    <= 32'h0;
            r_op     <= 4'h0;
            r_vec    <= '0;
            r_lfsr_a <= SEED_A;
            r_lfsr_b <= SEED_B;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_sig    <= 32'h0;
                    r_zerr   <= 1'b0;
                    r_pass   <= 1'b0;
                    r_op     <= 4'h0;
                    r_vec    <= '0;
                    r_lfsr_a <= SEED_A;
                    r_lfsr_b <= SEED_B;
                    r_inA    <= 32'h0;
                    r_inB    <= 32'h0;
                    r_state  <= S_DRIVE;
                end
                S_DRIVE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_sig  <= w_sig_nx;
                    r_zerr <= w_zerr_nx;
                    // Final (or failing) vector: operands stay frozen on it
                    if (w_to_done) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_sig_nx == GOLDEN_SIG) && !w_zerr_nx;
                    end else begin
                        r_vec    <= w_vec_nx;
                        r_op     <= w_op_nx;
                        r_lfsr_a <= w_lfsr_a_nx;
                        r_lfsr_b <= w_lfsr_b_nx;
                        r_inA    <= w_inA_nx;
                        r_inB    <= w_inB_nx;
                        r_state  <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign zero_err  = r_zerr;
    assign signature = r_sig;
    assign alu_inA   = r_inA;
    assign alu_inB   = r_inB;
    assign alu_op    = r_op;

endmodule
